// File: rtl/scr1_imem_resp_model.sv
// -----------------------------------------------------------------------------
// scr1_imem_resp_model
// Responder for the core instruction-memory interface. Requests are accepted
// into a small in-order pending FIFO and answered LATENCY cycles apart with
// OKAY (storage data) or ERR (write, misaligned or out-of-range address).
// Storage is a word array that is filled through the ld_* preload port.
//
// Optional feature macro: SCR1_IMEM_CMD_INJECT_EN
//   When defined, adds inj_vld/inj_addr/inj_data. A matching OKAY response
//   returns inj_data instead of the storage word.
// -----------------------------------------------------------------------------
module scr1_imem_resp_model #(
    parameter int MEM_WORDS  = 1024,
    parameter int LATENCY    = 2,
    parameter int PEND_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         imem_req,
    input  logic                         imem_cmd,
    input  logic [31:0]                  imem_addr,
    output logic                         imem_req_ack,
    output logic [31:0]                  imem_rdata,
    output logic [1:0]                   imem_resp,
    input  logic                         ld_we,
    input  logic [$clog2(MEM_WORDS)-1:0] ld_addr,
    input  logic [31:0]                  ld_wdata
`ifdef SCR1_IMEM_CMD_INJECT_EN
    ,
    input  logic                         inj_vld,
    input  logic [31:0]                  inj_addr,
    input  logic [31:0]                  inj_data
`endif
);

    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam int          PTR_W     = $clog2(PEND_DEPTH);
    localparam logic [3:0]  CNT_LAST  = 4'(LATENCY - 1);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

    localparam logic [1:0] RESP_IDLE = 2'b00;
    localparam logic [1:0] RESP_OKAY = 2'b01;
    localparam logic [1:0] RESP_ERR  = 2'b10;

    // A FIFO entry holds the error flag above an address tag. With injection
    // the tag is the full word address so it can be compared with inj_addr;
    // otherwise only the storage index is kept.
`ifdef SCR1_IMEM_CMD_INJECT_EN
    localparam int TAG_W = 30;
`else
    localparam int TAG_W = IDX_W;
`endif

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    logic [31:0]      mem      [MEM_WORDS];
    logic [TAG_W:0]   fifo_mem [PEND_DEPTH];

    logic [PTR_W:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W:0]   rd_ptr_reg, rd_ptr_next;
    logic [3:0]       cnt_reg, cnt_next;
    state_t           state_reg, state_next;
    logic [1:0]       resp_reg;
    logic [31:0]      rdata_reg;

    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             req_err;
    logic [TAG_W:0]   push_entry;
    logic [TAG_W:0]   head_entry;
    logic [IDX_W-1:0] head_idx;
    logic [31:0]      head_data;

    // Full when the pointers index the same slot but differ in the wrap bit.
    assign fifo_full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                          (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    // Ack comes only from registered state; a pop in the same cycle does not
    // free a slot early.
    assign imem_req_ack = ~fifo_full;
    assign push         = imem_req & ~fifo_full;

    assign req_err    = imem_cmd | (imem_addr[1:0] != 2'b00) |
                        ({1'b0, imem_addr} >= MEM_BYTES);
    assign push_entry = {req_err, imem_addr[TAG_W+1:2]};

    assign head_entry = fifo_mem[rd_ptr_reg[PTR_W-1:0]];
    assign head_idx   = head_entry[IDX_W-1:0];

`ifdef SCR1_IMEM_CMD_INJECT_EN
    logic inj_hit;
    assign inj_hit   = inj_vld && (inj_addr == {head_entry[TAG_W-1:0], 2'b00});
    assign head_data = inj_hit ? inj_data : mem[head_idx];
`else
    assign head_data = mem[head_idx];
`endif

    assign wr_ptr_next = push ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
    assign rd_ptr_next = pop  ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

    assign imem_resp  = resp_reg;
    assign imem_rdata = rdata_reg;

    // Preload port writes storage; storage is never cleared by reset.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_addr] <= ld_wdata;
        end
    end

    // Pending-request slots; contents need no reset since pointers gate them.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= push_entry;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: waiting whenever any request will be outstanding.
    always_comb begin
        state_next = ST_IDLE;
        if (wr_ptr_next != rd_ptr_next) begin
            state_next = ST_WAIT;
        end
    end

    // FSM outputs: latency counting and the pop/respond decision.
    always_comb begin
        pop      = 1'b0;
        cnt_next = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
            end
            ST_WAIT: begin
                if (cnt_reg == CNT_LAST) begin
                    pop      = 1'b1;
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            default: begin
                cnt_next = '0;
            end
        endcase
    end

    // Pointers, counter and the registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
            resp_reg   <= RESP_IDLE;
            rdata_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            cnt_reg    <= cnt_next;
            if (pop) begin
                if (head_entry[TAG_W]) begin
                    resp_reg  <= RESP_ERR;
                    rdata_reg <= '0;
                end else begin
                    resp_reg  <= RESP_OKAY;
                    rdata_reg <= head_data;
                end
            end else begin
                resp_reg <= RESP_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_scr1_imem_resp_model.sv
// -----------------------------------------------------------------------------
// tb_scr1_imem_resp_model
// Randomized and directed bench. A transaction-level model predicts, for every
// accepted request, its response edge (max(accept, previous response) +
// LATENCY), its kind and its data from a shadow copy of storage.
// -----------------------------------------------------------------------------
module tb_scr1_imem_resp_model;

    localparam int MEM_WORDS  = 1024;
    localparam int LATENCY    = 2;
    localparam int PEND_DEPTH = 2;
    localparam int IDX_W      = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             imem_req = 1'b0;
    logic             imem_cmd = 1'b0;
    logic [31:0]      imem_addr = '0;
    logic             imem_req_ack;
    logic [31:0]      imem_rdata;
    logic [1:0]       imem_resp;
    logic             ld_we = 1'b0;
    logic [IDX_W-1:0] ld_addr = '0;
    logic [31:0]      ld_wdata = '0;
`ifdef SCR1_IMEM_CMD_INJECT_EN
    logic             inj_vld = 1'b0;
    logic [31:0]      inj_addr = '0;
    logic [31:0]      inj_data = '0;
`endif

    scr1_imem_resp_model #(
        .MEM_WORDS  (MEM_WORDS),
        .LATENCY    (LATENCY),
        .PEND_DEPTH (PEND_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_cmd     (imem_cmd),
        .imem_addr    (imem_addr),
        .imem_req_ack (imem_req_ack),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .ld_we        (ld_we),
        .ld_addr      (ld_addr),
        .ld_wdata     (ld_wdata)
`ifdef SCR1_IMEM_CMD_INJECT_EN
        ,
        .inj_vld      (inj_vld),
        .inj_addr     (inj_addr),
        .inj_data     (inj_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cmd;
        logic [31:0] addr;
    } req_t;

    typedef struct {
        logic        err;
        logic [31:0] addr;
        int          due;
    } exp_t;

    req_t        issue_q[$];
    exp_t        exp_q[$];
    logic [31:0] mem_m [MEM_WORDS];
    int          cyc      = 0;
    int          last_due = 0;
    int          n_chk    = 0;
    int          n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_data(input exp_t e);
        logic [31:0] d;
        d = mem_m[e.addr[11:2]];
`ifdef SCR1_IMEM_CMD_INJECT_EN
        if (inj_vld && inj_addr == e.addr) d = inj_data;
`endif
        return d;
    endfunction

    function automatic logic model_err(input req_t r);
        return r.cmd || (r.addr[1:0] != 2'b00) || ({1'b0, r.addr} >= 33'(MEM_WORDS * 4));
    endfunction

    // One clock cycle: drive inputs, check ack, take the edge, then check the
    // response produced by that edge against the model.
    task automatic cycle(input logic we, input logic [IDX_W-1:0] la, input logic [31:0] ld);
        logic exp_ack;
        logic will_accept;
        req_t r;
        exp_t e;
        ld_we    = we;
        ld_addr  = la;
        ld_wdata = ld;
        if (rst_n && issue_q.size() > 0) begin
            r         = issue_q[0];
            imem_req  = 1'b1;
            imem_cmd  = r.cmd;
            imem_addr = r.addr;
        end else begin
            imem_req  = 1'b0;
            imem_cmd  = 1'($urandom_range(0, 1));
            imem_addr = $urandom;
        end
        exp_ack = (exp_q.size() < PEND_DEPTH);
        check_eq("ack", 32'(imem_req_ack), 32'(exp_ack));
        will_accept = rst_n && imem_req && exp_ack;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check_eq("resp", 32'(imem_resp), e.err ? 32'd2 : 32'd1);
            check_eq("rdata", imem_rdata, e.err ? 32'd0 : model_data(e));
            $display("resp cycle %0d addr %h %s data %h", cyc, e.addr,
                     e.err ? "ERR " : "OKAY", imem_rdata);
        end else begin
            check_eq("resp_idle", 32'(imem_resp), 32'd0);
        end
        if (!rst_n) check_eq("rst_rdata", imem_rdata, 32'd0);
        if (we) mem_m[la] = ld;
        if (will_accept) begin
            void'(issue_q.pop_front());
            e.err    = model_err(r);
            e.addr   = r.addr;
            e.due    = ((cyc > last_due) ? cyc : last_due) + LATENCY;
            last_due = e.due;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0);
    endtask

    task automatic push_req(input logic cmd, input logic [31:0] addr);
        req_t r;
        r.cmd  = cmd;
        r.addr = addr;
        issue_q.push_back(r);
    endtask

    initial begin
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rst_resp_async", 32'(imem_resp), 32'd0);
        check_eq("rst_rdata_async", imem_rdata, 32'd0);

        // Preload all of storage while in reset; word 4 holds the known pattern.
        for (int i = 0; i < MEM_WORDS; i++) begin
            cycle(1'b1, IDX_W'(i), (i == 4) ? 32'h057E4505 : $urandom);
        end
        idle(3);
        rst_n = 1'b1;

        // Single read of 0x10.
        push_req(1'b0, 32'h10);
        idle(6);

        // Back-to-back reads with the third stalled.
        push_req(1'b0, 32'h0);
        push_req(1'b0, 32'h4);
        push_req(1'b0, 32'h8);
        idle(12);

        // Error responses interleaved with a good read.
        push_req(1'b1, 32'h0);
        push_req(1'b0, 32'h2);
        push_req(1'b0, 32'h14);
        push_req(1'b0, 32'(MEM_WORDS * 4));
        push_req(1'b0, 32'h18);
        idle(16);

        // Reset while two requests are pending.
        push_req(1'b0, 32'h0);
        push_req(1'b0, 32'h4);
        idle(2);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_resp", 32'(imem_resp), 32'd0);
        check_eq("midrst_rdata", imem_rdata, 32'd0);
        exp_q.delete();
        issue_q.delete();
        last_due = 0;
        idle(3);
        rst_n = 1'b1;
        idle(6);

        // Preload collides with the response edge for 0x20.
        push_req(1'b0, 32'h20);
        idle(2);
        cycle(1'b1, IDX_W'(8), 32'hA5A5_0F0F);
        push_req(1'b0, 32'h20);
        idle(6);

`ifdef SCR1_IMEM_CMD_INJECT_EN
        // Injected data overrides a single word address only.
        cycle(1'b1, IDX_W'(16), 32'h0);
        inj_vld  = 1'b1;
        inj_addr = 32'h40;
        inj_data = 32'h057E4505;
        push_req(1'b0, 32'h40);
        push_req(1'b0, 32'h44);
        push_req(1'b1, 32'h40);
        idle(12);
`endif

        // Randomized traffic with occasional preload writes.
        for (int i = 0; i < 800; i++) begin
            if (issue_q.size() < 2 && $urandom_range(0, 99) < 60) begin
                case ($urandom_range(0, 19))
                    0:       push_req(1'b1, {20'd0, 10'($urandom_range(0, 1023)), 2'b00});
                    1:       push_req(1'b0, {20'd0, 10'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))});
                    2:       push_req(1'b0, 32'(MEM_WORDS * 4) + 32'($urandom_range(0, 4095)));
                    default: push_req(1'b0, {20'd0, 10'($urandom_range(0, 1023)), 2'b00});
                endcase
            end
            if ($urandom_range(0, 9) == 0) cycle(1'b1, IDX_W'($urandom_range(0, 1023)), $urandom);
            else                          cycle(1'b0, '0, '0);
        end
        issue_q.delete();
        idle(4 * LATENCY * PEND_DEPTH + 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
